// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: turns single-cycle set/clear requests into width-controlled,
// non-overlapping set/reset pulses for a NOR latch. Each pulse is followed by a
// guard gap, and the block tracks the expected latch state in q_model.
module sr_pulse_driver #(
  parameter int PULSE_W  = 2,
  parameter int GAP_W    = 1,
  parameter int INIT_CLR = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic set,
  output logic reset,
  output logic busy,
  output logic q_model,
  output logic err_conflict,
  output logic dropped
);

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;

  // Values loaded into the down-counter when a phase starts; the phase ends
  // on the edge that sees the counter at zero.
  localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_W - 1);
  localparam logic       INIT_LD  = (INIT_CLR != 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       init_q, init_d;
  logic       set_q, set_d;
  logic       reset_q, reset_d;
  logic       busy_q, busy_d;
  logic       q_model_q, q_model_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;

  // Next-state, counter and flag computation; outputs derive from the next state
  // so that set/reset/busy are plain flops with no decode glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_d    = init_q;
    q_model_d = q_model_q;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_q) begin
          // Power-up clear takes priority; anything requested alongside it is lost.
          state_d = RST_P;
          cnt_d   = PULSE_LD;
          init_d  = 1'b0;
          drop_d  = set_req | clr_req;
        end else if (set_req && !clr_req) begin
          state_d = SET_P;
          cnt_d   = PULSE_LD;
        end else if (clr_req && !set_req) begin
          state_d = RST_P;
          cnt_d   = PULSE_LD;
        end else if (set_req && clr_req) begin
          err_d = 1'b1;
        end
      end
      SET_P, RST_P: begin
        drop_d = set_req | clr_req;
        if (cnt_q == 8'd0) begin
          // Latch state is taken as settled on the edge the pulse falls.
          state_d   = GAP;
          cnt_d     = GAP_LD;
          q_model_d = (state_q == SET_P);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        drop_d = set_req | clr_req;
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    set_d   = (state_d == SET_P);
    reset_d = (state_d == RST_P);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      init_q    <= INIT_LD;
      set_q     <= 1'b0;
      reset_q   <= 1'b0;
      busy_q    <= 1'b0;
      q_model_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_q    <= init_d;
      set_q     <= set_d;
      reset_q   <= reset_d;
      busy_q    <= busy_d;
      q_model_q <= q_model_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign set          = set_q;
  assign reset        = reset_q;
  assign busy         = busy_q;
  assign q_model      = q_model_q;
  assign err_conflict = err_q;
  assign dropped      = drop_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Testbench: several sr_pulse_driver instances with different parameters share
// one stimulus stream and are compared each cycle against a timeline model.
module tb_sr_pulse_driver;

  localparam int NI = 5;
  localparam int PW_T   [NI] = '{2, 1, 3, 4, 2};
  localparam int GW_T   [NI] = '{1, 3, 3, 1, 1};
  localparam int INIT_T [NI] = '{1, 1, 0, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic [NI-1:0] set_o, reset_o, busy_o, q_o, err_o, drop_o;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sr_pulse_driver #(
      .PULSE_W (PW_T[gi]),
      .GAP_W   (GW_T[gi]),
      .INIT_CLR(INIT_T[gi])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .set_req     (set_req),
      .clr_req     (clr_req),
      .set         (set_o[gi]),
      .reset       (reset_o[gi]),
      .busy        (busy_o[gi]),
      .q_model     (q_o[gi]),
      .err_conflict(err_o[gi]),
      .dropped     (drop_o[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  // Model: each instance remembers the edge index of its last accepted pulse
  // and what kind it was; every output is derived from the distance to it.
  int acc_edge [NI];
  bit acc_set  [NI];
  bit m_q      [NI];
  bit m_init   [NI];
  bit e_set    [NI];
  bit e_reset  [NI];
  bit e_busy   [NI];
  bit e_err    [NI];
  bit e_drop   [NI];
  int edge_k = 0;
  int n_pulses = 0;

  task automatic check_val(input string tag, input int inst, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", tag, inst, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check_val("set",      i, 32'(set_o[i]),   32'(e_set[i]));
      check_val("reset",    i, 32'(reset_o[i]), 32'(e_reset[i]));
      check_val("busy",     i, 32'(busy_o[i]),  32'(e_busy[i]));
      check_val("q_model",  i, 32'(q_o[i]),     32'(m_q[i]));
      check_val("conflict", i, 32'(err_o[i]),   32'(e_err[i]));
      check_val("dropped",  i, 32'(drop_o[i]),  32'(e_drop[i]));
      check_val("overlap",  i, 32'(set_o[i] & reset_o[i]), 32'd0);
    end
  endtask

  // Predict the outputs after the coming rising edge given the inputs it samples.
  task automatic model_step(input bit r, input bit s, input bit c);
    for (int i = 0; i < NI; i++) begin
      int d;
      if (r) begin
        acc_edge[i] = -1;
        m_q[i]      = 1'b0;
        m_init[i]   = (INIT_T[i] != 0);
        e_err[i]    = 1'b0;
        e_drop[i]   = 1'b0;
      end else begin
        e_err[i]  = 1'b0;
        e_drop[i] = 1'b0;
        if (acc_edge[i] >= 0 && edge_k - acc_edge[i] == PW_T[i]) m_q[i] = acc_set[i];
        if (e_busy[i]) begin
          e_drop[i] = s | c;
        end else if (m_init[i]) begin
          acc_edge[i] = edge_k;
          acc_set[i]  = 1'b0;
          m_init[i]   = 1'b0;
          e_drop[i]   = s | c;
        end else if (s && !c) begin
          acc_edge[i] = edge_k;
          acc_set[i]  = 1'b1;
          if (i == 0) n_pulses++;
        end else if (c && !s) begin
          acc_edge[i] = edge_k;
          acc_set[i]  = 1'b0;
          if (i == 0) n_pulses++;
        end else if (s && c) begin
          e_err[i] = 1'b1;
        end
      end
      d = edge_k - acc_edge[i];
      e_set[i]   = !r && acc_edge[i] >= 0 && acc_set[i]  && d < PW_T[i];
      e_reset[i] = !r && acc_edge[i] >= 0 && !acc_set[i] && d < PW_T[i];
      e_busy[i]  = !r && acc_edge[i] >= 0 && d < PW_T[i] + GW_T[i];
    end
    edge_k++;
  endtask

  // One cycle: check what the last edge produced, then drive the next inputs.
  task automatic cyc(input bit r, input bit s, input bit c);
    @(negedge clk);
    check_all();
    rst     = r;
    set_req = s;
    clr_req = c;
    model_step(r, s, c);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      acc_edge[i] = -1; acc_set[i] = 1'b0; m_q[i] = 1'b0;
      m_init[i] = (INIT_T[i] != 0);
      e_set[i] = 1'b0; e_reset[i] = 1'b0; e_busy[i] = 1'b0;
      e_err[i] = 1'b0; e_drop[i] = 1'b0;
    end

    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle(10);
    $display("txn init_release: auto clear pulses done t=%0t", $time);

    cyc(1'b0, 1'b1, 1'b0); idle(10);
    $display("txn set_req t=%0t", $time);
    cyc(1'b0, 1'b0, 1'b1); idle(10);
    $display("txn clr_req t=%0t", $time);
    cyc(1'b0, 1'b1, 1'b1); idle(3);
    $display("txn conflict t=%0t", $time);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b1); idle(10);
    $display("txn clr_during_set_and_gap t=%0t", $time);

    // Reset in the middle of a set pulse must clear outputs before any edge.
    cyc(1'b0, 1'b1, 1'b0); idle(2);
    @(negedge clk);
    check_all();
    check_val("pre_rst_set", 3, 32'(set_o[3]), 32'd1);
    rst = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_val("async_set",   i, 32'(set_o[i]),   32'd0);
      check_val("async_busy",  i, 32'(busy_o[i]),  32'd0);
      check_val("async_reset", i, 32'(reset_o[i]), 32'd0);
      check_val("async_q",     i, 32'(q_o[i]),     32'd0);
    end
    model_step(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    idle(10);
    $display("txn async_reset_mid_pulse t=%0t", $time);

    for (int n = 0; n < 10000; n++) begin
      bit r;
      r = ($urandom_range(0, 2999) == 0);
      cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(10);
    $display("txn random: %0d pulses accepted on inst0 t=%0t", n_pulses, $time);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
